// File: rtl/hazard_scoreboard.sv
// Operand forwarding and hazard scoreboard for the ID stage.
// Resolves NUM_RD source operands over NUM_FWD producer stages and tracks
// in-flight register writes with per-register latency countdowns.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_valid_i        ID holds a valid instruction
//   id_rs_addr_i      NUM_RD packed 5-bit source register addresses
//   id_rs_used_i      per-port "operand actually read"
//   rf_rdata_i        NUM_RD packed regfile read data
//   id_rd_we_i        instruction writes rd
//   id_rd_addr_i      destination register
//   id_lat_i          cycles until result is on the forward network ('1 = LONG)
//   fwd_we_i          per-stage write enable
//   fwd_addr_i        per-stage destination (packed 5-bit)
//   fwd_data_i        per-stage result (packed XLEN)
//   fwd_ready_i       per-stage result valid this cycle
//   retire_i          writeback commits retire_addr_i this cycle
//   retire_addr_i     committed register
//   long_done_i       long-latency unit finished for long_addr_i
//   long_addr_i       register of the long-latency result
//   flush_i           kill younger in-flight work
//   rs_data_o         NUM_RD packed resolved operands
//   stall_o           hold ID/IF this cycle
//   issue_o           instruction leaves ID this cycle
//   busy_cnt_o        number of pending scoreboard entries
module hazard_scoreboard #(
   parameter int XLEN    = 32,
   parameter int NUM_RD  = 2,
   parameter int NUM_FWD = 3,
   parameter int LATW    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid_i,
   input  logic [NUM_RD*5-1:0]     id_rs_addr_i,
   input  logic [NUM_RD-1:0]       id_rs_used_i,
   input  logic [NUM_RD*XLEN-1:0]  rf_rdata_i,
   input  logic                    id_rd_we_i,
   input  logic [4:0]              id_rd_addr_i,
   input  logic [LATW-1:0]         id_lat_i,
   input  logic [NUM_FWD-1:0]      fwd_we_i,
   input  logic [NUM_FWD*5-1:0]    fwd_addr_i,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
   input  logic [NUM_FWD-1:0]      fwd_ready_i,
   input  logic                    retire_i,
   input  logic [4:0]              retire_addr_i,
   input  logic                    long_done_i,
   input  logic [4:0]              long_addr_i,
   input  logic                    flush_i,
   output logic [NUM_RD*XLEN-1:0]  rs_data_o,
   output logic                    stall_o,
   output logic                    issue_o,
   output logic [5:0]              busy_cnt_o
);

   localparam logic [LATW-1:0] LONG = '1;

   logic [31:0]     pend;
   logic [31:0]     pend_nxt;
   logic [LATW-1:0] cnt     [32];
   logic [LATW-1:0] cnt_nxt [32];
   logic [5:0]      busy_nxt;
   logic [NUM_RD-1:0] port_stall;
   logic            waw;

   // Operand resolve: youngest matching stage wins; a match that is not
   // ready is a hazard even if an older stage could supply the value.
   always_comb begin : resolve
      logic [4:0] a;
      logic       found;
      rs_data_o  = '0;
      port_stall = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a     = id_rs_addr_i[5*k +: 5];
         found = 1'b0;
         if (id_rs_used_i[k] && a != 5'd0) begin
            rs_data_o[XLEN*k +: XLEN] = rf_rdata_i[XLEN*k +: XLEN];
            for (int j = 0; j < NUM_FWD; j++) begin
               if (!found && fwd_we_i[j] && fwd_addr_i[5*j +: 5] == a) begin
                  found = 1'b1;
                  if (fwd_ready_i[j])
                     rs_data_o[XLEN*k +: XLEN] = fwd_data_i[XLEN*j +: XLEN];
                  else
                     port_stall[k] = 1'b1;
               end
            end
            if (pend[a] && cnt[a] != '0)
               port_stall[k] = 1'b1;
         end
      end
   end

   // A LONG write still in flight must not be overtaken by a younger write.
   assign waw = id_rd_we_i && id_rd_addr_i != 5'd0 &&
                pend[id_rd_addr_i] && cnt[id_rd_addr_i] == LONG;

   assign stall_o = ~rst & id_valid_i & ((|port_stall) | waw);
   assign issue_o = id_valid_i & ~stall_o & ~flush_i & ~rst;

   // Later assignments take priority: countdown, long done, retire,
   // flush, then a new issue to the same register.
   always_comb begin
      pend_nxt    = '0;
      cnt_nxt[0]  = '0;
      busy_nxt    = '0;
      for (int i = 1; i < 32; i++) begin
         pend_nxt[i] = pend[i];
         cnt_nxt[i]  = cnt[i];
         if (cnt[i] != '0 && cnt[i] != LONG)
            cnt_nxt[i] = cnt[i] - 1'b1;
         if (long_done_i && long_addr_i == 5'(i))
            cnt_nxt[i] = '0;
         if (retire_i && retire_addr_i == 5'(i)) begin
            pend_nxt[i] = 1'b0;
            cnt_nxt[i]  = '0;
         end
         if (flush_i && cnt[i] != LONG) begin
            pend_nxt[i] = 1'b0;
            cnt_nxt[i]  = '0;
         end
         if (issue_o && id_rd_we_i && id_rd_addr_i == 5'(i)) begin
            pend_nxt[i] = 1'b1;
            cnt_nxt[i]  = id_lat_i;
         end
         busy_nxt = busy_nxt + {5'd0, pend_nxt[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend       <= '0;
         busy_cnt_o <= '0;
         for (int i = 0; i < 32; i++)
            cnt[i] <= '0;
      end else begin
         pend       <= pend_nxt;
         busy_cnt_o <= busy_nxt;
         for (int i = 0; i < 32; i++)
            cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard.
// Each scenario task drives vectors and checks hand-computed results.
module tb_hazard_scoreboard;

   localparam int XLEN = 32;
   localparam int NR   = 2;
   localparam int NF   = 3;
   localparam int LATW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [NR*5-1:0]   id_rs_addr;
   logic [NR-1:0]     id_rs_used;
   logic [NR*XLEN-1:0] rf_rdata;
   logic              id_rd_we;
   logic [4:0]        id_rd_addr;
   logic [LATW-1:0]   id_lat;
   logic [NF-1:0]     fwd_we;
   logic [NF*5-1:0]   fwd_addr;
   logic [NF*XLEN-1:0] fwd_data;
   logic [NF-1:0]     fwd_ready;
   logic              retire;
   logic [4:0]        retire_addr;
   logic              long_done;
   logic [4:0]        long_addr;
   logic              flush;
   logic [NR*XLEN-1:0] rs_data;
   logic              stall;
   logic              issue;
   logic [5:0]        busy_cnt;

   int checks = 0;
   int passed = 0;

   hazard_scoreboard #(
      .XLEN(XLEN), .NUM_RD(NR), .NUM_FWD(NF), .LATW(LATW)
   ) dut (
      .clk(clk), .rst(rst),
      .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
      .id_rs_used_i(id_rs_used), .rf_rdata_i(rf_rdata),
      .id_rd_we_i(id_rd_we), .id_rd_addr_i(id_rd_addr),
      .id_lat_i(id_lat), .fwd_we_i(fwd_we), .fwd_addr_i(fwd_addr),
      .fwd_data_i(fwd_data), .fwd_ready_i(fwd_ready),
      .retire_i(retire), .retire_addr_i(retire_addr),
      .long_done_i(long_done), .long_addr_i(long_addr),
      .flush_i(flush), .rs_data_o(rs_data), .stall_o(stall),
      .issue_o(issue), .busy_cnt_o(busy_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clr();
      id_valid = 0; id_rs_addr = '0; id_rs_used = '0;
      rf_rdata = {32'hDEAD0002, 32'hDEAD0001};
      id_rd_we = 0; id_rd_addr = '0; id_lat = '0;
      fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_ready = '0;
      retire = 0; retire_addr = '0; long_done = 0; long_addr = '0;
      flush = 0;
   endtask

   // advance to just after the next rising edge, then clear inputs
   task automatic tick();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic issue_wr(input logic [4:0] rd, input logic [2:0] lat);
      id_valid = 1; id_rd_we = 1; id_rd_addr = rd; id_lat = lat;
   endtask

   task automatic test_reset();
      rst = 1;
      clr();
      tick();
      issue_wr(5'd1, 3'd1);
      id_rs_addr[4:0] = 5'd1; id_rs_used = 2'b01;
      #1;
      checks++;
      if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall);
      else passed++;
      checks++;
      if (issue !== 1'b0) $display("FAIL rst_issue got %b exp 0", issue);
      else passed++;
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL rst_busy got %0d exp 0", busy_cnt);
      else passed++;
      tick();
      rst = 0;
      tick();
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL rst_busy_after got %0d exp 0", busy_cnt);
      else passed++;
   endtask

   task automatic test_fwd_lat0();
      tick();
      issue_wr(5'd5, 3'd0);
      #1;
      checks++;
      if (issue !== 1'b1) $display("FAIL fwd0_issue got %b exp 1", issue);
      else passed++;
      tick();
      id_valid = 1;
      id_rs_addr = {5'd0, 5'd5}; id_rs_used = 2'b11;
      fwd_we = 3'b001; fwd_addr[4:0] = 5'd5;
      fwd_data[31:0] = 32'h1234; fwd_ready = 3'b001;
      #1;
      checks++;
      if (rs_data[31:0] !== 32'h1234)
         $display("FAIL fwd0_data got %h exp 00001234", rs_data[31:0]);
      else passed++;
      checks++;
      if (rs_data[63:32] !== 32'h0)
         $display("FAIL fwd0_x0 got %h exp 00000000", rs_data[63:32]);
      else passed++;
      checks++;
      if (stall !== 1'b0) $display("FAIL fwd0_stall got %b exp 0", stall);
      else passed++;
      checks++;
      if (busy_cnt !== 6'd1) $display("FAIL fwd0_busy got %0d exp 1", busy_cnt);
      else passed++;
      tick();
      retire = 1; retire_addr = 5'd5;
      tick();
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL fwd0_retire got %0d exp 0", busy_cnt);
      else passed++;
   endtask

   task automatic test_load_use();
      tick();
      issue_wr(5'd7, 3'd1);
      tick();
      id_valid = 1; id_rs_addr[4:0] = 5'd7; id_rs_used = 2'b01;
      fwd_we = 3'b001; fwd_addr[4:0] = 5'd7; fwd_ready = 3'b000;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", stall);
      else passed++;
      checks++;
      if (issue !== 1'b0) $display("FAIL lu_issue got %b exp 0", issue);
      else passed++;
      tick();
      id_valid = 1; id_rs_addr[4:0] = 5'd7; id_rs_used = 2'b01;
      fwd_we = 3'b010; fwd_addr[9:5] = 5'd7;
      fwd_data[63:32] = 32'h55AA; fwd_ready = 3'b010;
      #1;
      checks++;
      if (stall !== 1'b0) $display("FAIL lu_go got %b exp 0", stall);
      else passed++;
      checks++;
      if (rs_data[31:0] !== 32'h55AA)
         $display("FAIL lu_data got %h exp 000055aa", rs_data[31:0]);
      else passed++;
      tick();
      retire = 1; retire_addr = 5'd7;
      tick();
   endtask

   task automatic test_long();
      tick();
      issue_wr(5'd8, 3'd7);
      tick();
      for (int n = 0; n < 3; n++) begin
         id_valid = 1; id_rs_addr[4:0] = 5'd8; id_rs_used = 2'b01;
         #1;
         checks++;
         if (stall !== 1'b1) $display("FAIL long_stall%0d got %b exp 1", n, stall);
         else passed++;
         tick();
      end
      issue_wr(5'd8, 3'd1);
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL long_waw got %b exp 1", stall);
      else passed++;
      tick();
      id_valid = 1; id_rs_addr[4:0] = 5'd8; id_rs_used = 2'b01;
      long_done = 1; long_addr = 5'd8;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL long_done_cyc got %b exp 1", stall);
      else passed++;
      tick();
      id_valid = 1; id_rs_addr[4:0] = 5'd8; id_rs_used = 2'b01;
      fwd_we = 3'b100; fwd_addr[14:10] = 5'd8;
      fwd_data[95:64] = 32'h777; fwd_ready = 3'b100;
      #1;
      checks++;
      if (issue !== 1'b1) $display("FAIL long_issue got %b exp 1", issue);
      else passed++;
      checks++;
      if (rs_data[31:0] !== 32'h777)
         $display("FAIL long_data got %h exp 00000777", rs_data[31:0]);
      else passed++;
      checks++;
      if (busy_cnt !== 6'd1) $display("FAIL long_busy got %0d exp 1", busy_cnt);
      else passed++;
      tick();
      retire = 1; retire_addr = 5'd8;
      tick();
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL long_retire got %0d exp 0", busy_cnt);
      else passed++;
   endtask

   task automatic test_priority();
      tick();
      id_valid = 1;
      id_rs_addr = {5'd5, 5'd5}; id_rs_used = 2'b01;
      fwd_we = 3'b101; fwd_addr = {5'd5, 5'd0, 5'd5};
      fwd_data = {32'hB, 32'h0, 32'hA}; fwd_ready = 3'b101;
      #1;
      checks++;
      if (rs_data[31:0] !== 32'hA)
         $display("FAIL prio_young got %h exp 0000000a", rs_data[31:0]);
      else passed++;
      checks++;
      if (rs_data[63:32] !== 32'h0)
         $display("FAIL prio_unused got %h exp 00000000", rs_data[63:32]);
      else passed++;
      fwd_we = 3'b100;
      id_rs_addr[9:5] = 5'd9; id_rs_used = 2'b11;
      #1;
      checks++;
      if (rs_data[31:0] !== 32'hB)
         $display("FAIL prio_old got %h exp 0000000b", rs_data[31:0]);
      else passed++;
      checks++;
      if (rs_data[63:32] !== 32'hDEAD0002)
         $display("FAIL prio_rf got %h exp dead0002", rs_data[63:32]);
      else passed++;
   endtask

   task automatic test_flush();
      tick();
      issue_wr(5'd3, 3'd2);
      tick();
      issue_wr(5'd4, 3'd7);
      tick();
      issue_wr(5'd10, 3'd1);
      flush = 1;
      #1;
      checks++;
      if (issue !== 1'b0) $display("FAIL flush_issue got %b exp 0", issue);
      else passed++;
      tick();
      id_valid = 1; id_rs_addr = {5'd4, 5'd3}; id_rs_used = 2'b01;
      #1;
      checks++;
      if (stall !== 1'b0) $display("FAIL flush_x3 got %b exp 0", stall);
      else passed++;
      id_rs_used = 2'b10;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL flush_x4 got %b exp 1", stall);
      else passed++;
      checks++;
      if (busy_cnt !== 6'd1) $display("FAIL flush_busy got %0d exp 1", busy_cnt);
      else passed++;
      tick();
      long_done = 1; long_addr = 5'd4;
      retire = 1; retire_addr = 5'd4;
      tick();
      id_valid = 1; id_rs_addr[9:5] = 5'd4; id_rs_used = 2'b10;
      #1;
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL done_ret_busy got %0d exp 0", busy_cnt);
      else passed++;
      checks++;
      if (stall !== 1'b0) $display("FAIL done_ret_stall got %b exp 0", stall);
      else passed++;
   endtask

   task automatic test_reset_mid();
      tick();
      issue_wr(5'd12, 3'd5);
      tick();
      id_valid = 1; id_rs_addr[4:0] = 5'd12; id_rs_used = 2'b01;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL rmid_pre got %b exp 1", stall);
      else passed++;
      tick();
      rst = 1;
      id_valid = 1; id_rs_addr[4:0] = 5'd12; id_rs_used = 2'b01;
      #1;
      checks++;
      if (stall !== 1'b0) $display("FAIL rmid_in got %b exp 0", stall);
      else passed++;
      tick();
      rst = 0;
      id_valid = 1; id_rs_addr[4:0] = 5'd12; id_rs_used = 2'b01;
      #1;
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL rmid_busy got %0d exp 0", busy_cnt);
      else passed++;
      checks++;
      if (stall !== 1'b0) $display("FAIL rmid_stall got %b exp 0", stall);
      else passed++;
   endtask

   task automatic test_back_to_back();
      tick();
      issue_wr(5'd13, 3'd0);
      tick();
      issue_wr(5'd14, 3'd0);
      #1;
      checks++;
      if (issue !== 1'b1) $display("FAIL b2b_issue got %b exp 1", issue);
      else passed++;
      checks++;
      if (busy_cnt !== 6'd1) $display("FAIL b2b_busy1 got %0d exp 1", busy_cnt);
      else passed++;
      tick();
      issue_wr(5'd0, 3'd3);
      tick();
      issue_wr(5'd15, 3'd2);
      #1;
      checks++;
      if (busy_cnt !== 6'd2) $display("FAIL b2b_x0 got %0d exp 2", busy_cnt);
      else passed++;
      tick();
      for (int n = 0; n < 3; n++) begin
         id_valid = 1; id_rs_addr[4:0] = 5'd15; id_rs_used = 2'b01;
         #1;
         checks++;
         if (stall !== (n < 2))
            $display("FAIL b2b_cd%0d got %b exp %b", n, stall, n < 2);
         else passed++;
         tick();
      end
      checks++;
      if (busy_cnt !== 6'd3) $display("FAIL b2b_busy3 got %0d exp 3", busy_cnt);
      else passed++;
      retire = 1; retire_addr = 5'd13;
      tick();
      retire = 1; retire_addr = 5'd14;
      tick();
      retire = 1; retire_addr = 5'd15;
      issue_wr(5'd15, 3'd0);
      tick();
      checks++;
      if (busy_cnt !== 6'd1) $display("FAIL b2b_issue_wins got %0d exp 1", busy_cnt);
      else passed++;
      retire = 1; retire_addr = 5'd15;
      tick();
      checks++;
      if (busy_cnt !== 6'd0) $display("FAIL b2b_empty got %0d exp 0", busy_cnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_fwd_lat0();
      test_load_use();
      test_long();
      test_priority();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
